// File: rtl/mdu32_if.sv
// Request/response bundle between the execute-stage controller and the multiply/divide unit.
// No latency of its own; pure wiring.
// Controller must stall while Busy is high; Start is ignored by the unit while busy.
interface mdu32_if;
    logic        Start;
    logic [5:0]  Function_opcode;
    logic [31:0] Read_data_1;
    logic [31:0] Read_data_2;
    logic        Busy;
    logic        Done;
    logic        Div_zero;
    logic [31:0] Hi;
    logic [31:0] Lo;

    modport master (
        output Start, Function_opcode, Read_data_1, Read_data_2,
        input  Busy, Done, Div_zero, Hi, Lo
    );

    modport slave (
        input  Start, Function_opcode, Read_data_1, Read_data_2,
        output Busy, Done, Div_zero, Hi, Lo
    );
endinterface

// File: rtl/mdu32.sv
// Iterative 32-bit multiply/divide unit owning the architectural Hi/Lo registers.
// Latency: 33 cycles from accepted Start to Hi/Lo update; mthi/mtlo take effect at the Start edge.
// Backpressure: Busy high during CALC/FIX; every Start (including mthi/mtlo) is dropped while busy.
module mdu32 (
    input  logic   clock,
    input  logic   reset_n,
    mdu32_if.slave bus
);
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_cnt;
    logic [63:0] r_acc;        // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [31:0] r_opnd;       // magnitude of multiplicand or divisor
    logic [31:0] r_rs_orig;    // untouched rs, returned in Hi on divide-by-zero
    logic        r_is_div, r_signed, r_neg_rs, r_neg_rt, r_dz;
    logic [31:0] r_hi, r_lo;
    logic        r_done, r_div_zero;

    logic        w_idle, w_accept, w_is_div_op, w_signed_op, w_mthi, w_mtlo;
    logic [31:0] w_abs_rs, w_abs_rt;
    logic [32:0] w_mul_sum, w_div_rem, w_div_trial;
    logic [63:0] w_acc_step, w_prod;
    logic [31:0] w_hi_fix, w_lo_fix;

    assign w_idle      = (r_state == S_IDLE);
    assign w_accept    = w_idle && bus.Start &&
                         (bus.Function_opcode == OP_MULT || bus.Function_opcode == OP_MULTU ||
                          bus.Function_opcode == OP_DIV  || bus.Function_opcode == OP_DIVU);
    assign w_mthi      = w_idle && bus.Start && (bus.Function_opcode == OP_MTHI);
    assign w_mtlo      = w_idle && bus.Start && (bus.Function_opcode == OP_MTLO);
    assign w_is_div_op = (bus.Function_opcode == OP_DIV) || (bus.Function_opcode == OP_DIVU);
    assign w_signed_op = (bus.Function_opcode == OP_MULT) || (bus.Function_opcode == OP_DIV);

    // 0x80000000 negates to itself, which is the right magnitude when read as unsigned.
    assign w_abs_rs = (w_signed_op && bus.Read_data_1[31]) ? (~bus.Read_data_1 + 32'd1) : bus.Read_data_1;
    assign w_abs_rt = (w_signed_op && bus.Read_data_2[31]) ? (~bus.Read_data_2 + 32'd1) : bus.Read_data_2;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state: IDLE -> CALC on accept, 32 iterations, one FIX cycle, back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_CALC;
            S_CALC:  if (r_cnt == 5'd31) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One radix-2 step: shift-add multiply or restoring divide.
    // The shifted remainder is below 2*divisor, so a non-negative trial always fits in 32 bits
    // and bit 32 of the 33-bit trial is a reliable sign.
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[63:32]} + {1'b0, r_opnd};
        w_div_rem   = r_acc[63:31];
        w_div_trial = w_div_rem - {1'b0, r_opnd};
        w_acc_step  = r_acc;
        if (!r_is_div) begin
            if (r_acc[0]) w_acc_step = {w_mul_sum, r_acc[31:1]};
            else          w_acc_step = {1'b0, r_acc[63:1]};
        end else begin
            if (!w_div_trial[32]) w_acc_step = {w_div_trial[31:0], r_acc[30:0], 1'b1};
            else                  w_acc_step = {r_acc[62:0], 1'b0};
        end
    end

    // Sign correction and divide-by-zero substitution applied when results retire.
    always_comb begin
        w_prod   = r_acc;
        w_hi_fix = r_acc[63:32];
        w_lo_fix = r_acc[31:0];
        if (!r_is_div) begin
            if (r_signed && (r_neg_rs ^ r_neg_rt)) w_prod = ~r_acc + 64'd1;
            w_hi_fix = w_prod[63:32];
            w_lo_fix = w_prod[31:0];
        end else if (r_dz) begin
            w_hi_fix = r_rs_orig;
            w_lo_fix = 32'hFFFF_FFFF;
        end else begin
            if (r_signed && (r_neg_rs ^ r_neg_rt)) w_lo_fix = ~r_acc[31:0] + 32'd1;
            if (r_signed && r_neg_rs)              w_hi_fix = ~r_acc[63:32] + 32'd1;
        end
    end

    // Operand capture, iteration, result retirement and mthi/mtlo writes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= 5'd0;
            r_acc      <= 64'd0;
            r_opnd     <= 32'd0;
            r_rs_orig  <= 32'd0;
            r_is_div   <= 1'b0;
            r_signed   <= 1'b0;
            r_neg_rs   <= 1'b0;
            r_neg_rt   <= 1'b0;
            r_dz       <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc      <= {32'd0, (w_is_div_op ? w_abs_rs : w_abs_rt)};
                        r_opnd     <= w_is_div_op ? w_abs_rt : w_abs_rs;
                        r_rs_orig  <= bus.Read_data_1;
                        r_is_div   <= w_is_div_op;
                        r_signed   <= w_signed_op;
                        r_neg_rs   <= w_signed_op && bus.Read_data_1[31];
                        r_neg_rt   <= w_signed_op && bus.Read_data_2[31];
                        r_dz       <= w_is_div_op && (bus.Read_data_2 == 32'd0);
                        r_cnt      <= 5'd0;
                        r_div_zero <= 1'b0;
                    end else if (w_mthi) begin
                        r_hi <= bus.Read_data_1;
                    end else if (w_mtlo) begin
                        r_lo <= bus.Read_data_1;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_step;
                    r_cnt <= r_cnt + 5'd1;
                end
                S_FIX: begin
                    r_hi       <= w_hi_fix;
                    r_lo       <= w_lo_fix;
                    r_done     <= 1'b1;
                    r_div_zero <= r_dz;
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy     = !w_idle;
    assign bus.Done     = r_done;
    assign bus.Div_zero = r_div_zero;
    assign bus.Hi       = r_hi;
    assign bus.Lo       = r_lo;
endmodule

// File: tb/tb_mdu32.sv
module tb_mdu32;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;

    logic clock;
    logic reset_n;
    int   n_vec = 0;
    int   n_bad = 0;

    mdu32_if bus();

    mdu32 dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, want completion");
        $fatal(1, "watchdog");
    end

    // Reference: {Div_zero, Hi, Lo} from plain 64-bit arithmetic.
    function automatic logic [64:0] model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, tq, tr, tp;
        logic [63:0] p;
        logic [31:0] hi, lo;
        logic        dz;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            OP_MULT:  begin tp = sa * sb; p = tp; hi = p[63:32]; lo = p[31:0]; end
            OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            OP_DIV: begin
                if (b == 32'd0) begin dz = 1'b1; hi = a; lo = 32'hFFFF_FFFF; end
                else begin tq = sa / sb; tr = sa % sb; lo = tq[31:0]; hi = tr[31:0]; end
            end
            OP_DIVU: begin
                if (b == 32'd0) begin dz = 1'b1; hi = a; lo = 32'hFFFF_FFFF; end
                else begin lo = a / b; hi = a % b; end
            end
            default: ;
        endcase
        return {dz, hi, lo};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issues one op (caller is at a negedge) and returns at the negedge where Done is seen.
    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cyc, output logic got_done);
        bus.Start = 1'b1; bus.Function_opcode = op; bus.Read_data_1 = a; bus.Read_data_2 = b;
        @(negedge clock);
        bus.Start = 1'b0;
        bus.Read_data_1 = $urandom; bus.Read_data_2 = $urandom;
        busy_cyc = 0; got_done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.Busy) busy_cyc++;
            if (bus.Done) begin got_done = 1'b1; break; end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.Start = 1'b0; bus.Function_opcode = 6'd0; bus.Read_data_1 = 32'd0; bus.Read_data_2 = 32'd0;
        #1;
        n_vec++;
        if ({bus.Busy, bus.Done, bus.Div_zero, bus.Hi, bus.Lo} !== 67'd0) begin
            n_bad++;
            $display("FAIL reset_state: got busy=%b done=%b dz=%b hi=%h lo=%h, want all zero",
                     bus.Busy, bus.Done, bus.Div_zero, bus.Hi, bus.Lo);
        end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_directed();
        logic [31:0] ta[6];
        logic [31:0] tb[6];
        logic [5:0]  to[6];
        logic [64:0] want[6];
        logic [64:0] exp;
        int          bc;
        logic        gd;
        to[0] = OP_MULT;  ta[0] = 32'hFFFF_FFFD; tb[0] = 32'd5;          want[0] = {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        to[1] = OP_MULTU; ta[1] = 32'hFFFF_FFFF; tb[1] = 32'hFFFF_FFFF;  want[1] = {1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
        to[2] = OP_DIV;   ta[2] = 32'hFFFF_FFF9; tb[2] = 32'd2;          want[2] = {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        to[3] = OP_DIV;   ta[3] = 32'h8000_0000; tb[3] = 32'hFFFF_FFFF;  want[3] = {1'b0, 32'h0000_0000, 32'h8000_0000};
        to[4] = OP_DIVU;  ta[4] = 32'd7;         tb[4] = 32'd0;          want[4] = {1'b1, 32'h0000_0007, 32'hFFFF_FFFF};
        to[5] = OP_DIVU;  ta[5] = 32'd7;         tb[5] = 32'd2;          want[5] = {1'b0, 32'h0000_0001, 32'h0000_0003};
        for (int k = 0; k < 6; k++) begin
            exp = want[k];
            run_op(to[k], ta[k], tb[k], bc, gd);
            n_vec++;
            if (!gd || bc != 33) begin
                n_bad++;
                $display("FAIL directed%0d_timing: got done=%b busy_cycles=%0d, want done=1 busy_cycles=33", k, gd, bc);
            end
            n_vec++;
            if ({bus.Div_zero, bus.Hi, bus.Lo} !== exp) begin
                n_bad++;
                $display("FAIL directed%0d_result: got dz=%b hi=%h lo=%h, want dz=%b hi=%h lo=%h",
                         k, bus.Div_zero, bus.Hi, bus.Lo, exp[64], exp[63:32], exp[31:0]);
            end
            @(negedge clock);
            n_vec++;
            if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
                n_bad++;
                $display("FAIL directed%0d_done_pulse: got done=%b busy=%b one cycle later, want 0 0", k, bus.Done, bus.Busy);
            end
        end
    endtask

    task automatic test_mthi_mtlo();
        bus.Start = 1'b1; bus.Function_opcode = OP_MTHI; bus.Read_data_1 = 32'h0000_1234;
        @(negedge clock);
        bus.Start = 1'b0; bus.Read_data_1 = 32'hAAAA_AAAA;
        n_vec++;
        if (bus.Hi !== 32'h0000_1234 || bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
            n_bad++;
            $display("FAIL mthi: got hi=%h busy=%b done=%b, want hi=00001234 busy=0 done=0", bus.Hi, bus.Busy, bus.Done);
        end
        bus.Start = 1'b1; bus.Function_opcode = OP_MTLO; bus.Read_data_1 = 32'h0000_5678;
        @(negedge clock);
        bus.Start = 1'b0;
        n_vec++;
        if (bus.Lo !== 32'h0000_5678 || bus.Hi !== 32'h0000_1234 || bus.Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mtlo: got hi=%h lo=%h busy=%b, want hi=00001234 lo=00005678 busy=0", bus.Hi, bus.Lo, bus.Busy);
        end
        // An unrecognised opcode with Start must change nothing.
        bus.Start = 1'b1; bus.Function_opcode = 6'b100000; bus.Read_data_1 = 32'hDEAD_BEEF;
        @(negedge clock);
        bus.Start = 1'b0;
        @(negedge clock);
        n_vec++;
        if (bus.Lo !== 32'h0000_5678 || bus.Hi !== 32'h0000_1234 || bus.Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL bad_opcode: got hi=%h lo=%h busy=%b, want hi=00001234 lo=00005678 busy=0", bus.Hi, bus.Lo, bus.Busy);
        end
    endtask

    task automatic test_random();
        logic [5:0]  ops[4];
        logic [5:0]  op;
        logic [31:0] a, b;
        logic [64:0] exp;
        int          bc;
        logic        gd;
        ops[0] = OP_MULT; ops[1] = OP_MULTU; ops[2] = OP_DIV; ops[3] = OP_DIVU;
        for (int k = 0; k < 24; k++) begin
            op = ops[$urandom_range(0, 3)];
            a = pick(); b = pick();
            exp = model(op, a, b);
            run_op(op, a, b, bc, gd);
            n_vec++;
            if (!gd || bc != 33 || {bus.Div_zero, bus.Hi, bus.Lo} !== exp) begin
                n_bad++;
                $display("FAIL random%0d op=%b a=%h b=%h: got done=%b busy=%0d dz=%b hi=%h lo=%h, want done=1 busy=33 dz=%b hi=%h lo=%h",
                         k, op, a, b, gd, bc, bus.Div_zero, bus.Hi, bus.Lo, exp[64], exp[63:32], exp[31:0]);
            end
            if ($urandom_range(0, 1) == 1) @(negedge clock);
        end
    endtask

    task automatic test_busy_ignore();
        logic [64:0] exp;
        int          bc;
        logic        gd;
        exp = model(OP_MULT, 32'h0001_2345, 32'hFFFF_0F00);
        bus.Start = 1'b1; bus.Function_opcode = OP_MULT; bus.Read_data_1 = 32'h0001_2345; bus.Read_data_2 = 32'hFFFF_0F00;
        @(negedge clock);
        bus.Start = 1'b0;
        bc = 0; gd = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.Busy) bc++;
            if (bus.Done) begin gd = 1'b1; break; end
            bus.Read_data_1 = $urandom; bus.Read_data_2 = $urandom;
            bus.Start = (i == 4) || (i == 9) || (i == 31);
            bus.Function_opcode = (i == 4) ? OP_MTLO : (i == 31 ? OP_MTHI : OP_MULT);
            @(negedge clock);
        end
        bus.Start = 1'b0;
        n_vec++;
        if (!gd || bc != 33 || {bus.Hi, bus.Lo} !== exp[63:0]) begin
            n_bad++;
            $display("FAIL busy_ignore: got done=%b busy=%0d hi=%h lo=%h, want done=1 busy=33 hi=%h lo=%h",
                     gd, bc, bus.Hi, bus.Lo, exp[63:32], exp[31:0]);
        end
        @(negedge clock);
        n_vec++;
        if ({bus.Hi, bus.Lo} !== exp[63:0] || bus.Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_ignore_hold: got hi=%h lo=%h busy=%b, want hi=%h lo=%h busy=0",
                     bus.Hi, bus.Lo, bus.Busy, exp[63:32], exp[31:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  op[3];
        logic [31:0] a[3];
        logic [31:0] b[3];
        logic [64:0] exp;
        int          bc;
        logic        gd;
        op[0] = OP_DIVU; a[0] = 32'd100;       b[0] = 32'd0;
        op[1] = OP_DIV;  a[1] = 32'hFFFF_FF00; b[1] = 32'd7;
        op[2] = OP_MULT; a[2] = 32'h8000_0000; b[2] = 32'h8000_0000;
        for (int k = 0; k < 3; k++) begin
            exp = model(op[k], a[k], b[k]);
            run_op(op[k], a[k], b[k], bc, gd);
            n_vec++;
            if (!gd || bc != 33 || {bus.Div_zero, bus.Hi, bus.Lo} !== exp) begin
                n_bad++;
                $display("FAIL back_to_back%0d: got done=%b busy=%0d dz=%b hi=%h lo=%h, want done=1 busy=33 dz=%b hi=%h lo=%h",
                         k, gd, bc, bus.Div_zero, bus.Hi, bus.Lo, exp[64], exp[63:32], exp[31:0]);
            end
        end
        @(negedge clock);
    endtask

    task automatic test_reset_midop();
        logic [64:0] exp;
        int          bc;
        logic        gd;
        logic        saw_done;
        bus.Start = 1'b1; bus.Function_opcode = OP_DIV; bus.Read_data_1 = 32'd1000; bus.Read_data_2 = 32'd7;
        @(negedge clock);
        bus.Start = 1'b0;
        repeat (9) @(negedge clock);
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.Busy, bus.Done, bus.Div_zero, bus.Hi, bus.Lo} !== 67'd0) begin
            n_bad++;
            $display("FAIL reset_midop: got busy=%b done=%b dz=%b hi=%h lo=%h, want all zero",
                     bus.Busy, bus.Done, bus.Div_zero, bus.Hi, bus.Lo);
        end
        @(negedge clock);
        reset_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (bus.Done || bus.Busy) saw_done = 1'b1;
        end
        n_vec++;
        if (saw_done !== 1'b0 || {bus.Hi, bus.Lo} !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_discard: got activity=%b hi=%h lo=%h, want activity=0 hi=0 lo=0", saw_done, bus.Hi, bus.Lo);
        end
        exp = model(OP_MULT, 32'd12345, 32'hFFFF_FFF0);
        run_op(OP_MULT, 32'd12345, 32'hFFFF_FFF0, bc, gd);
        n_vec++;
        if (!gd || bc != 33 || {bus.Hi, bus.Lo} !== exp[63:0]) begin
            n_bad++;
            $display("FAIL after_reset_mult: got done=%b busy=%0d hi=%h lo=%h, want done=1 busy=33 hi=%h lo=%h",
                     gd, bc, bus.Hi, bus.Lo, exp[63:32], exp[31:0]);
        end
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mthi_mtlo();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
